// File: rtl/upcount_stopwatch.sv
// Up-counting stopwatch: prescaled one-second ticks, BCD elapsed seconds,
// progress steps every d seconds, and a one-shot timeout at the latched limit.
module upcount_stopwatch #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic [3:0] difficulty,
   output logic       sec_tick,
   output logic [3:0] elapsed_tens,
   output logic [3:0] elapsed_ones,
   output logic [4:0] progress,
   output logic       running,
   output logic       timeout
);

   localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;
   logic [4:0]    prog_q, prog_d;
   logic [3:0]    step_q, step_d;
   logic [3:0]    lim_q, lim_d;
   logic          tick_q, tick_d, tout_q, tout_d, run_q, run_d;

   logic [3:0] ones_inc, tens_inc;
   logic       terminal, hit;

   always_comb begin
      terminal = (presc_q == PRE_LAST);
      ones_inc = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
      tens_inc = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
      // d=0 free-runs to 99; otherwise the limit is d tens and zero ones
      hit = (lim_q == 4'd0) ? (tens_inc == 4'd9 && ones_inc == 4'd9)
                            : (tens_inc == lim_q && ones_inc == 4'd0);
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      prog_d  = prog_q;
      step_d  = step_q;
      lim_d   = lim_q;
      tick_d  = 1'b0;
      tout_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
         presc_d = '0;
         tens_d  = 4'd0;
         ones_d  = 4'd0;
         prog_d  = 5'd0;
         step_d  = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  state_d = RUNNING;
                  lim_d   = (difficulty > 4'd9) ? 4'd9 : difficulty;
               end
            end
            RUNNING: begin
               if (terminal) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  tens_d  = tens_inc;
                  ones_d  = ones_inc;
                  if (lim_q != 4'd0) begin
                     if (step_q == lim_q - 4'd1) begin
                        step_d = 4'd0;
                        prog_d = prog_q + 5'd1;
                     end else begin
                        step_d = step_q + 4'd1;
                     end
                  end
                  // reaching the limit wins over a coincident stop
                  if (hit) begin
                     state_d = DONE;
                     tout_d  = 1'b1;
                  end else if (stop) begin
                     state_d = PAUSED;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
                  if (stop) state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (start && !stop) state_d = RUNNING;
            end
            default: ;
         endcase
      end
      run_d = (state_d == RUNNING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         prog_q  <= 5'd0;
         step_q  <= 4'd0;
         lim_q   <= 4'd0;
         tick_q  <= 1'b0;
         tout_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         prog_q  <= prog_d;
         step_q  <= step_d;
         lim_q   <= lim_d;
         tick_q  <= tick_d;
         tout_q  <= tout_d;
         run_q   <= run_d;
      end
   end

   assign sec_tick     = tick_q;
   assign timeout      = tout_q;
   assign elapsed_tens = tens_q;
   assign elapsed_ones = ones_q;
   assign progress     = prog_q;
   assign running      = run_q;

endmodule

// File: tb/tb_upcount_stopwatch.sv
// Bench for upcount_stopwatch at CLK_FREQ=4: an integer-seconds reference model
// queues expected outputs per driven cycle; they are popped after each edge.
module tb_upcount_stopwatch;

   localparam int CF = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
   logic [3:0] difficulty = 4'd0;
   logic       sec_tick, timeout, running;
   logic [3:0] elapsed_tens, elapsed_ones;
   logic [4:0] progress;

   upcount_stopwatch #(.CLK_FREQ(CF)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .difficulty(difficulty), .sec_tick(sec_tick), .elapsed_tens(elapsed_tens),
      .elapsed_ones(elapsed_ones), .progress(progress), .running(running),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   logic [15:0] exp_q[$];

   // model: 0 idle, 1 running, 2 paused, 3 done; elapsed kept as plain integer
   int m_st = 0, m_pre = 0, m_el = 0, m_d = 0;
   bit m_tick = 0, m_to = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
   endtask

   function automatic logic [15:0] model_out();
      int lim_prog;
      lim_prog = (m_d > 0) ? m_el / m_d : 0;
      return {m_tick, m_to, 4'(m_el / 10), 4'(m_el % 10), 5'(lim_prog),
              (m_st == 1) ? 1'b1 : 1'b0};
   endfunction

   task automatic model_step(input bit r, s, p, c, input int dif);
      int lim;
      m_tick = 0; m_to = 0;
      lim = (m_d == 0) ? 99 : 10 * m_d;
      if (r) begin
         m_st = 0; m_pre = 0; m_el = 0; m_d = 0;
      end else if (c) begin
         m_st = 0; m_pre = 0; m_el = 0;
      end else begin
         case (m_st)
            0: if (s && !p) begin m_st = 1; m_d = (dif > 9) ? 9 : dif; end
            1: begin
               if (m_pre == CF - 1) begin
                  m_pre = 0; m_el++; m_tick = 1;
                  if (m_el == lim) begin m_st = 3; m_to = 1; end
                  else if (p) m_st = 2;
               end else begin
                  m_pre++;
                  if (p) m_st = 2;
               end
            end
            2: if (s && !p) m_st = 1;
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input bit r, s, p, c, input logic [3:0] dif);
      logic [15:0] got;
      @(negedge clk);
      reset = r; start = s; stop = p; clear = c; difficulty = dif;
      model_step(r, s, p, c, int'(dif));
      exp_q.push_back(model_out());
      @(posedge clk); #1;
      got = {sec_tick, timeout, elapsed_tens, elapsed_ones, progress, running};
      chk("cycle", got, exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, difficulty);
   endtask

   initial begin
      // reset state
      cyc(1, 0, 0, 0, 4'd0);
      cyc(1, 1, 0, 0, 4'd5);
      chk("reset_all", {sec_tick, timeout, elapsed_tens, elapsed_ones, progress, running}, 16'h0);

      // difficulty 2: limit 20 s, progress every 2 ticks
      cyc(0, 1, 0, 0, 4'd2);
      idle(2 * CF);
      chk("d2_prog_after_2", {11'd0, progress}, 16'd1);
      idle(18 * CF);
      chk("d2_digits", {8'd0, elapsed_tens, elapsed_ones}, 16'h0020);
      chk("d2_prog", {11'd0, progress}, 16'd10);
      idle(10);

      // clear+start together in DONE goes to IDLE
      cyc(0, 1, 0, 1, 4'd2);
      chk("clr_done", {sec_tick, timeout, elapsed_tens, elapsed_ones, progress, running}, 16'h0);

      // free run to 99
      cyc(0, 1, 0, 0, 4'd0);
      idle(99 * CF + 8);
      chk("d0_digits", {8'd0, elapsed_tens, elapsed_ones}, 16'h0099);

      // pause mid-second, resume; stop+start together pauses
      cyc(0, 0, 0, 1, 4'd3);
      cyc(0, 1, 0, 0, 4'd3);
      idle(CF + 1);
      cyc(0, 0, 1, 0, 4'd3);
      idle(10);
      cyc(0, 1, 0, 0, 4'd3);
      idle(2 * CF + 1);
      cyc(0, 1, 1, 0, 4'd3);
      idle(5);
      cyc(0, 1, 0, 0, 4'd3);
      idle(3 * CF);

      // difficulty 12 clamps to 9; stop on the 90th tick cycle still ends in DONE
      cyc(0, 0, 0, 1, 4'd12);
      cyc(0, 1, 0, 0, 4'd12);
      idle(90 * CF - 1);
      cyc(0, 0, 1, 0, 4'd12);
      chk("d12_digits", {8'd0, elapsed_tens, elapsed_ones}, 16'h0090);
      chk("d12_prog", {11'd0, progress}, 16'd10);
      idle(8);

      // reset mid-run at 0/5
      cyc(0, 0, 0, 1, 4'd0);
      cyc(0, 1, 0, 0, 4'd0);
      idle(5 * CF + 2);
      cyc(1, 0, 0, 0, 4'd0);
      chk("rst_run", {sec_tick, timeout, elapsed_tens, elapsed_ones, progress, running}, 16'h0);
      idle(8);

      // random mix of controls
      for (int i = 0; i < 600; i++)
         cyc(($urandom % 100) < 1, ($urandom % 100) < 12, ($urandom % 100) < 5,
             ($urandom % 100) < 2, 4'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/upcount_stopwatch.md
UPCOUNT_STOPWATCH -- requirements
Module: upcount_stopwatch

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk cycles per elapsed second (minimum 2).
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, start/resume request (level, sampled each cycle).
REQ-005 SHALL have port stop, input, 1, pause request.
REQ-006 SHALL have port clear, input, 1, return to IDLE with zeroed count.
REQ-007 SHALL have port difficulty, input, 4, seconds per progress step; latched at start from IDLE.
REQ-008 SHALL have port sec_tick, output, 1, one-cycle pulse per counted second (secclk source for downstream countdowns).
REQ-009 SHALL have port elapsed_tens, output, 4, BCD tens digit of elapsed seconds.
REQ-010 SHALL have port elapsed_ones, output, 4, BCD ones digit of elapsed seconds.
REQ-011 SHALL have port progress, output, 5, up-count progress 0..10.
REQ-012 SHALL have port running, output, 1, high only in RUNNING.
REQ-013 SHALL have port timeout, output, 1, one-cycle pulse on entry to DONE.

Function
REQ-014 SHALL implement states IDLE, RUNNING, PAUSED, DONE; all outputs registered.
REQ-015 SHALL latch limit difficulty on IDLE->RUNNING: d = min(difficulty, 9); d=0 means free-run with limit 99, else limit 10*d seconds.
REQ-016 SHALL give priority clear > stop > start in every state; clear from any state -> IDLE next cycle, zeroing prescaler, digits, progress, step counter.
REQ-017 IDLE: start (without stop/clear) -> RUNNING; stop alone ignored.
REQ-018 RUNNING: prescaler counts 0..CLK_FREQ-1; on the cycle it equals CLK_FREQ-1 it wraps to 0, and next cycle sec_tick=1 and elapsed is incremented by one (first tick exactly CLK_FREQ cycles after entering RUNNING).
REQ-019 SHALL increment elapsed in BCD: ones 9 -> 0 with tens+1; never produce non-BCD digit values.
REQ-020 stop in RUNNING -> PAUSED; if that cycle is the prescaler terminal cycle, the tick and increment still occur.
REQ-021 PAUSED: prescaler, digits, progress frozen; start -> RUNNING resuming from frozen prescaler value (no lost partial second).
REQ-022 progress SHALL increment by 1 every d counted seconds (step counter 0..d-1, wraps on increment); with d=0 progress stays 0.
REQ-023 When an increment makes elapsed equal limit: state -> DONE, timeout=1 for exactly that cycle, coincident with the final sec_tick and digit update; progress reads 10 when d>0.
REQ-024 Elapsed reaching limit SHALL override a simultaneous stop (DONE, not PAUSED).
REQ-025 DONE: all values held, no further sec_tick, start/stop ignored; only clear or reset leaves.
REQ-026 sec_tick and timeout SHALL be 0 in all cycles other than those defined above.

Reset
REQ-027 reset SHALL take effect on the next clk edge regardless of state, overriding all inputs.
REQ-028 After reset: state IDLE, prescaler 0, elapsed_tens=0, elapsed_ones=0, progress=0, running=0, sec_tick=0, timeout=0, latched limit 0.
REQ-029 reset asserted mid-second SHALL discard the partial prescaler count; no tick or timeout is emitted on or after the reset edge.

Verification (CLK_FREQ=4)
REQ-030 reset, start=1 one cycle, difficulty=2 -> running=1; sec_tick pulses every 4 cycles; progress 1 after 2 ticks; after 20 ticks digits 2/0, progress=10, timeout pulse, running=0.
REQ-031 difficulty=0, run 99 ticks -> digits step 0/9 -> 1/0 correctly; at 9/9 timeout pulse, DONE, no further ticks.
REQ-032 RUNNING, stop after 2 cycles into a second, hold 10 cycles, start -> next tick exactly 2 cycles after resume; digits unchanged during pause.
REQ-033 stop and start asserted together in RUNNING -> PAUSED; clear+start together in DONE -> IDLE, all zero.
REQ-034 difficulty=12 -> limit 90, progress steps every 9 ticks; stop on final (90th) tick cycle -> DONE with timeout.
REQ-035 reset asserted in RUNNING at elapsed 0/5 -> next cycle all outputs zero, state IDLE, no tick for 8 cycles without start.
